// File: rtl/saturn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | saturn_pkg                                                                 |
// | Shared widths, fetch-stage state type and opcode-length helper.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package saturn_pkg;

  localparam int SATURN_ADDR_W     = 20;
  localparam int SATURN_MAX_OP_NIB = 21;
  localparam int SATURN_LEN_W      = 5;
  localparam int SATURN_OPCODE_W   = 4 * SATURN_MAX_OP_NIB;

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_BKPT  = 2'd3
  } fetch_state_t;

  // A length of zero means the controller cannot size the opcode yet.
  function automatic logic len_ok(input logic [SATURN_LEN_W-1:0] len, input int max_nib);
    return (len != '0) && (int'(len) <= max_nib);
  endfunction

endpackage
`default_nettype wire

// File: rtl/saturn_fetch_bkpt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | saturn_fetch_bkpt                                                          |
// | Breakpoint compare with resume suppression; built with SATURN_FETCH_BKPT_EN.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`ifdef SATURN_FETCH_BKPT_EN
module saturn_fetch_bkpt
  import saturn_pkg::*;
(
  input  logic                     i_bkpt_en,
  input  logic [SATURN_ADDR_W-1:0] i_bkpt_addr,
  input  logic [SATURN_ADDR_W-1:0] i_pc,
  input  logic                     i_enter_fetch,
  input  logic                     i_resuming,
  output logic                     o_trap
);

  // Re-entering fetch out of the breakpoint itself must not trap again.
  assign o_trap = i_enter_fetch && i_bkpt_en && !i_resuming && (i_pc == i_bkpt_addr);

endmodule
`endif
`default_nettype wire

// File: rtl/saturn_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | saturn_fetch_unit                                                          |
// | Saturn fetch stage: PC, opcode capture, decoder handshake, jump flush.     |
// | Optional breakpoint support with macro SATURN_FETCH_BKPT_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module saturn_fetch_unit
  import saturn_pkg::*;
#(
  parameter logic [SATURN_ADDR_W-1:0] RESET_PC   = 20'h00000,
  parameter int                       MAX_OP_NIB = SATURN_MAX_OP_NIB
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  output logic [SATURN_ADDR_W-1:0]  ibus_addr_o,
  output logic                      ibus_flush_q_o,
  output logic                      ibus_fetch_o,
  output logic                      ibus_fetch_ack_o,
  output logic [SATURN_LEN_W-1:0]   ibus_size_o,
  input  logic                      ibus_ready_in,
  input  logic [SATURN_ADDR_W-1:0]  ibus_addr_in,
  input  logic [4*MAX_OP_NIB-1:0]   ibus_pre_fetched_opcode_in,
  input  logic [SATURN_LEN_W-1:0]   ibus_pre_fetched_opcode_length_in,
  output logic                      dec_valid_o,
  input  logic                      dec_ready_in,
  output logic [4*MAX_OP_NIB-1:0]   dec_opcode_o,
  output logic [SATURN_LEN_W-1:0]   dec_length_o,
  output logic [SATURN_ADDR_W-1:0]  dec_pc_o,
  output logic [SATURN_ADDR_W-1:0]  dec_next_pc_o,
  input  logic                      jump_in,
  input  logic [SATURN_ADDR_W-1:0]  jump_addr_in
`ifdef SATURN_FETCH_BKPT_EN
  ,
  input  logic                      bkpt_en_in,
  input  logic [SATURN_ADDR_W-1:0]  bkpt_addr_in,
  input  logic                      resume_in,
  output logic                      bkpt_hit_o
`endif
);

  fetch_state_t               r_state, w_next, w_next_base;
  logic [SATURN_ADDR_W-1:0]   r_pc, w_pc_next;
  logic                       r_flush, r_fetch, r_ack, r_valid;
  logic [SATURN_LEN_W-1:0]    r_size, r_len;
  logic [4*MAX_OP_NIB-1:0]    r_opcode;
  logic [SATURN_ADDR_W-1:0]   r_dec_pc, r_dec_next_pc;
  logic                       w_match, w_handshake;
  logic                       w_flush_d, w_fetch_d, w_valid_d, w_ack_d, w_capture;

  assign w_match = (r_state == S_FETCH) && ibus_ready_in && (ibus_addr_in == r_pc) &&
                   len_ok(ibus_pre_fetched_opcode_length_in, MAX_OP_NIB);
  assign w_handshake = (r_state == S_HOLD) && r_valid && dec_ready_in;

  // Reset parks in S_FLUSH with the pulse not yet issued; it repeats once to emit it.
  always_comb begin
    w_next_base = r_state;
    w_pc_next   = r_pc;
    if (jump_in) begin
      w_next_base = S_FLUSH;
      w_pc_next   = jump_addr_in;
    end else begin
      case (r_state)
        S_FLUSH: if (r_flush) w_next_base = S_FETCH;
        S_FETCH: if (w_match) w_next_base = S_HOLD;
        S_HOLD: begin
          if (w_handshake) begin
            w_next_base = S_FETCH;
            w_pc_next   = r_dec_next_pc;
          end
        end
`ifdef SATURN_FETCH_BKPT_EN
        S_BKPT:  if (resume_in) w_next_base = S_FETCH;
`endif
        default: w_next_base = S_FLUSH;
      endcase
    end
  end

`ifdef SATURN_FETCH_BKPT_EN
  logic w_enter_fetch, w_trap, r_bkpt_hit;

  assign w_enter_fetch = (w_next_base == S_FETCH) && (r_state != S_FETCH);

  saturn_fetch_bkpt u_bkpt (
    .i_bkpt_en     (bkpt_en_in),
    .i_bkpt_addr   (bkpt_addr_in),
    .i_pc          (w_pc_next),
    .i_enter_fetch (w_enter_fetch),
    .i_resuming    (r_state == S_BKPT),
    .o_trap        (w_trap)
  );

  assign w_next     = w_trap ? S_BKPT : w_next_base;
  assign bkpt_hit_o = r_bkpt_hit;
`else
  assign w_next = w_next_base;
`endif

  always_comb begin
    w_flush_d = (w_next == S_FLUSH);
    w_fetch_d = (w_next == S_FETCH);
    w_valid_d = (w_next == S_HOLD);
    w_ack_d   = w_handshake && !jump_in;
    w_capture = w_match && !jump_in;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state       <= S_FLUSH;
      r_pc          <= RESET_PC;
      r_flush       <= 1'b0;
      r_fetch       <= 1'b0;
      r_ack         <= 1'b0;
      r_valid       <= 1'b0;
      r_size        <= '0;
      r_len         <= '0;
      r_opcode      <= '0;
      r_dec_pc      <= RESET_PC;
      r_dec_next_pc <= '0;
`ifdef SATURN_FETCH_BKPT_EN
      r_bkpt_hit    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_flush <= w_flush_d;
      r_fetch <= w_fetch_d;
      r_valid <= w_valid_d;
      r_ack   <= w_ack_d;
`ifdef SATURN_FETCH_BKPT_EN
      r_bkpt_hit <= (w_next == S_BKPT);
`endif
      if (w_ack_d) r_size <= r_len;
      if (w_capture) begin
        r_opcode      <= ibus_pre_fetched_opcode_in;
        r_len         <= ibus_pre_fetched_opcode_length_in;
        r_dec_pc      <= r_pc;
        r_dec_next_pc <= r_pc + {{(SATURN_ADDR_W-SATURN_LEN_W){1'b0}},
                                 ibus_pre_fetched_opcode_length_in};
      end
    end
  end

  assign ibus_addr_o      = r_pc;
  assign ibus_flush_q_o   = r_flush;
  assign ibus_fetch_o     = r_fetch;
  assign ibus_fetch_ack_o = r_ack;
  assign ibus_size_o      = r_size;
  assign dec_valid_o      = r_valid;
  assign dec_opcode_o     = r_opcode;
  assign dec_length_o     = r_len;
  assign dec_pc_o         = r_dec_pc;
  assign dec_next_pc_o    = r_dec_next_pc;

endmodule
`default_nettype wire

// File: tb/tb_saturn_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_saturn_fetch_unit                                                       |
// | Self-checking bench for saturn_fetch_unit (breakpoints with the macro).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_saturn_fetch_unit;

  localparam int OPW = 84;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic [19:0]     ibus_addr_o;
  logic            ibus_flush_q_o, ibus_fetch_o, ibus_fetch_ack_o;
  logic [4:0]      ibus_size_o;
  logic            ibus_ready_in;
  logic [19:0]     ibus_addr_in;
  logic [OPW-1:0]  ibus_pre_fetched_opcode_in;
  logic [4:0]      ibus_pre_fetched_opcode_length_in;
  logic            dec_valid_o, dec_ready_in;
  logic [OPW-1:0]  dec_opcode_o;
  logic [4:0]      dec_length_o;
  logic [19:0]     dec_pc_o, dec_next_pc_o;
  logic            jump_in;
  logic [19:0]     jump_addr_in;
`ifdef SATURN_FETCH_BKPT_EN
  logic            bkpt_en_in, resume_in, bkpt_hit_o;
  logic [19:0]     bkpt_addr_in;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  saturn_fetch_unit #(.RESET_PC(20'h00000), .MAX_OP_NIB(21)) dut (
    .clk_in                            (clk_in),
    .reset_in                          (reset_in),
    .ibus_addr_o                       (ibus_addr_o),
    .ibus_flush_q_o                    (ibus_flush_q_o),
    .ibus_fetch_o                      (ibus_fetch_o),
    .ibus_fetch_ack_o                  (ibus_fetch_ack_o),
    .ibus_size_o                       (ibus_size_o),
    .ibus_ready_in                     (ibus_ready_in),
    .ibus_addr_in                      (ibus_addr_in),
    .ibus_pre_fetched_opcode_in        (ibus_pre_fetched_opcode_in),
    .ibus_pre_fetched_opcode_length_in (ibus_pre_fetched_opcode_length_in),
    .dec_valid_o                       (dec_valid_o),
    .dec_ready_in                      (dec_ready_in),
    .dec_opcode_o                      (dec_opcode_o),
    .dec_length_o                      (dec_length_o),
    .dec_pc_o                          (dec_pc_o),
    .dec_next_pc_o                     (dec_next_pc_o),
    .jump_in                           (jump_in),
    .jump_addr_in                      (jump_addr_in)
`ifdef SATURN_FETCH_BKPT_EN
    ,
    .bkpt_en_in                        (bkpt_en_in),
    .bkpt_addr_in                      (bkpt_addr_in),
    .resume_in                         (resume_in),
    .bkpt_hit_o                        (bkpt_hit_o)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [19:0] pc_add(input logic [19:0] pc, input logic [4:0] len);
    return 20'((int'(pc) + int'(len)) % (1 << 20));
  endfunction

  task automatic present(input logic [19:0] addr, input logic [OPW-1:0] op, input logic [4:0] len);
    ibus_ready_in = 1'b1;
    ibus_addr_in = addr;
    ibus_pre_fetched_opcode_in = op;
    ibus_pre_fetched_opcode_length_in = len;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    tick();
    tick();
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", dec_valid_o); end
    n_checks++; if (ibus_fetch_o !== 1'b0) begin n_fail++; $display("FAIL reset_fetch got %0b exp 0", ibus_fetch_o); end
    n_checks++; if (ibus_flush_q_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %0b exp 0", ibus_flush_q_o); end
    n_checks++; if (ibus_fetch_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %0b exp 0", ibus_fetch_ack_o); end
    n_checks++; if (ibus_addr_o !== 20'h0 || dec_pc_o !== 20'h0) begin n_fail++; $display("FAIL reset_pc got %0h/%0h exp 0", ibus_addr_o, dec_pc_o); end
    n_checks++; if (dec_opcode_o !== '0 || dec_length_o !== 5'd0 || ibus_size_o !== 5'd0 || dec_next_pc_o !== 20'h0) begin
      n_fail++; $display("FAIL reset_data got op=%0h len=%0d size=%0d npc=%0h exp 0", dec_opcode_o, dec_length_o, ibus_size_o, dec_next_pc_o);
    end
`ifdef SATURN_FETCH_BKPT_EN
    n_checks++; if (bkpt_hit_o !== 1'b0) begin n_fail++; $display("FAIL reset_bkpt got %0b exp 0", bkpt_hit_o); end
`endif
    reset_in = 1'b0;
    tick();
    n_checks++; if (ibus_flush_q_o !== 1'b1 || ibus_fetch_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_flush got flush=%0b fetch=%0b exp 1/0", ibus_flush_q_o, ibus_fetch_o); end
    tick();
    n_checks++; if (ibus_flush_q_o !== 1'b0 || ibus_fetch_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_fetch got flush=%0b fetch=%0b exp 0/1", ibus_flush_q_o, ibus_fetch_o); end
  endtask

  task automatic test_basic();
    logic [OPW-1:0] op;
    op = '0;
    op[7:0] = 8'h3C;
    present(20'h0, op, 5'd2);
    tick();
    ibus_ready_in = 1'b0;
    n_checks++; if (dec_valid_o !== 1'b1 || ibus_fetch_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid got valid=%0b fetch=%0b exp 1/0", dec_valid_o, ibus_fetch_o); end
    n_checks++; if (dec_pc_o !== 20'h0 || dec_next_pc_o !== 20'h2) begin n_fail++; $display("FAIL basic_pcs got %0h/%0h exp 0/2", dec_pc_o, dec_next_pc_o); end
    n_checks++; if (dec_opcode_o !== op || dec_length_o !== 5'd2) begin n_fail++; $display("FAIL basic_opcode got %0h/%0d exp %0h/2", dec_opcode_o, dec_length_o, op); end
    dec_ready_in = 1'b1;
    tick();
    dec_ready_in = 1'b0;
    n_checks++; if (ibus_fetch_ack_o !== 1'b1 || ibus_size_o !== 5'd2) begin n_fail++; $display("FAIL basic_ack got ack=%0b size=%0d exp 1/2", ibus_fetch_ack_o, ibus_size_o); end
    n_checks++; if (ibus_addr_o !== 20'h2 || ibus_fetch_o !== 1'b1 || dec_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_next got addr=%0h fetch=%0b valid=%0b exp 2/1/0", ibus_addr_o, ibus_fetch_o, dec_valid_o);
    end
    tick();
    n_checks++; if (ibus_fetch_ack_o !== 1'b0) begin n_fail++; $display("FAIL basic_ack_pulse got %0b exp 0", ibus_fetch_ack_o); end
  endtask

  task automatic test_wrap();
    jump_in = 1'b1;
    jump_addr_in = 20'hFFFFE;
    tick();
    jump_in = 1'b0;
    n_checks++; if (ibus_flush_q_o !== 1'b1 || ibus_addr_o !== 20'hFFFFE) begin n_fail++; $display("FAIL wrap_jump got flush=%0b addr=%0h exp 1/FFFFE", ibus_flush_q_o, ibus_addr_o); end
    tick();
    present(20'hFFFFE, 84'h123, 5'd3);
    tick();
    ibus_ready_in = 1'b0;
    n_checks++; if (dec_valid_o !== 1'b1 || dec_next_pc_o !== 20'h00001) begin n_fail++; $display("FAIL wrap_npc got valid=%0b npc=%0h exp 1/00001", dec_valid_o, dec_next_pc_o); end
    dec_ready_in = 1'b1;
    tick();
    dec_ready_in = 1'b0;
    n_checks++; if (ibus_addr_o !== 20'h00001 || ibus_size_o !== 5'd3) begin n_fail++; $display("FAIL wrap_addr got %0h/%0d exp 00001/3", ibus_addr_o, ibus_size_o); end
  endtask

  task automatic test_jump_squash();
    present(20'h00001, 84'hABCD, 5'd4);
    tick();
    ibus_ready_in = 1'b0;
    jump_in = 1'b1;
    jump_addr_in = 20'h12345;
    dec_ready_in = 1'b1;
    tick();
    jump_in = 1'b0;
    dec_ready_in = 1'b0;
    n_checks++; if (ibus_fetch_ack_o !== 1'b0) begin n_fail++; $display("FAIL squash_ack got %0b exp 0", ibus_fetch_ack_o); end
    n_checks++; if (ibus_flush_q_o !== 1'b1 || dec_valid_o !== 1'b0 || ibus_addr_o !== 20'h12345) begin
      n_fail++; $display("FAIL squash_flush got flush=%0b valid=%0b addr=%0h exp 1/0/12345", ibus_flush_q_o, dec_valid_o, ibus_addr_o);
    end
    present(20'h00002, 84'h77, 5'd2);
    tick();
    n_checks++; if (ibus_fetch_o !== 1'b1 || ibus_flush_q_o !== 1'b0) begin n_fail++; $display("FAIL squash_fetch got fetch=%0b flush=%0b exp 1/0", ibus_fetch_o, ibus_flush_q_o); end
    tick();
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL stale_ignored got valid=%0b exp 0", dec_valid_o); end
    present(20'h12345, 84'h5A5A5, 5'd5);
    tick();
    ibus_ready_in = 1'b0;
    n_checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 20'h12345 || dec_next_pc_o !== 20'h1234A) begin
      n_fail++; $display("FAIL jump_capture got valid=%0b pc=%0h npc=%0h exp 1/12345/1234A", dec_valid_o, dec_pc_o, dec_next_pc_o);
    end
    dec_ready_in = 1'b1;
    tick();
    dec_ready_in = 1'b0;
  endtask

  task automatic test_len_zero();
    present(20'h1234A, 84'h9, 5'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL len0_cycle%0d got valid=%0b exp 0", i, dec_valid_o); end
    end
    ibus_pre_fetched_opcode_length_in = 5'd22;
    tick();
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL len22 got valid=%0b exp 0", dec_valid_o); end
    ibus_pre_fetched_opcode_length_in = 5'd4;
    tick();
    ibus_ready_in = 1'b0;
    n_checks++; if (dec_valid_o !== 1'b1 || dec_length_o !== 5'd4) begin n_fail++; $display("FAIL len4 got valid=%0b len=%0d exp 1/4", dec_valid_o, dec_length_o); end
    dec_ready_in = 1'b1;
    tick();
    dec_ready_in = 1'b0;
    n_checks++; if (ibus_addr_o !== 20'h1234E) begin n_fail++; $display("FAIL len4_next got %0h exp 1234E", ibus_addr_o); end
  endtask

`ifdef SATURN_FETCH_BKPT_EN
  task automatic test_bkpt();
    bkpt_en_in = 1'b1;
    bkpt_addr_in = 20'h00010;
    jump_in = 1'b1;
    jump_addr_in = 20'h00010;
    tick();
    jump_in = 1'b0;
    tick();
    n_checks++; if (bkpt_hit_o !== 1'b1 || ibus_fetch_o !== 1'b0 || dec_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bkpt_hit got hit=%0b fetch=%0b valid=%0b exp 1/0/0", bkpt_hit_o, ibus_fetch_o, dec_valid_o);
    end
    present(20'h00010, 84'h21, 5'd2);
    tick();
    ibus_ready_in = 1'b0;
    n_checks++; if (bkpt_hit_o !== 1'b1 || dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL bkpt_hold got hit=%0b valid=%0b exp 1/0", bkpt_hit_o, dec_valid_o); end
    resume_in = 1'b1;
    tick();
    resume_in = 1'b0;
    n_checks++; if (bkpt_hit_o !== 1'b0 || ibus_fetch_o !== 1'b1 || ibus_addr_o !== 20'h00010) begin
      n_fail++; $display("FAIL bkpt_resume got hit=%0b fetch=%0b addr=%0h exp 0/1/10", bkpt_hit_o, ibus_fetch_o, ibus_addr_o);
    end
    present(20'h00010, 84'h21, 5'd2);
    tick();
    ibus_ready_in = 1'b0;
    dec_ready_in = 1'b1;
    tick();
    dec_ready_in = 1'b0;
    n_checks++; if (ibus_addr_o !== 20'h00012 || ibus_fetch_o !== 1'b1 || bkpt_hit_o !== 1'b0) begin
      n_fail++; $display("FAIL bkpt_after got addr=%0h fetch=%0b hit=%0b exp 12/1/0", ibus_addr_o, ibus_fetch_o, bkpt_hit_o);
    end
    bkpt_en_in = 1'b0;
  endtask
`endif

  // Reference: PC sequence advances by each accepted length modulo 2^20; jumps replace it.
  task automatic test_random();
    logic [95:0]    raw;
    logic [OPW-1:0] op;
    logic [4:0]     len;
    logic [19:0]    exp_pc, npc, tgt;
    int             n, kind;
    exp_pc = ibus_addr_o === 20'h00012 ? 20'h00012 : 20'h1234E;
    for (int t = 0; t < 40; t++) begin
      if (t == 0 || $urandom_range(0, 5) == 0) begin
        tgt = ($urandom_range(0, 1) == 1) ? 20'hFFFF0 + 20'($urandom_range(0, 15)) : 20'($urandom);
        jump_in = 1'b1;
        jump_addr_in = tgt;
        tick();
        jump_in = 1'b0;
        n_checks++; if (ibus_flush_q_o !== 1'b1 || ibus_addr_o !== tgt) begin n_fail++; $display("FAIL rnd_jump t=%0d got flush=%0b addr=%0h exp 1/%0h", t, ibus_flush_q_o, ibus_addr_o, tgt); end
        exp_pc = tgt;
        tick();
      end
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        kind = $urandom_range(0, 2);
        if (kind == 0) ibus_ready_in = 1'b0;
        else if (kind == 1) present(exp_pc ^ 20'($urandom_range(1, (1 << 20) - 1)), 84'h1, 5'd3);
        else begin
          n = $urandom_range(0, 10);
          present(exp_pc, 84'h1, (n == 0) ? 5'd0 : 5'(21 + n));
          n = 0;
        end
        tick();
        n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL rnd_noise t=%0d got valid=%0b exp 0", t, dec_valid_o); end
      end
      raw = {$urandom, $urandom, $urandom};
      op = raw[OPW-1:0];
      len = 5'($urandom_range(1, 21));
      npc = pc_add(exp_pc, len);
      present(exp_pc, op, len);
      tick();
      ibus_ready_in = 1'b0;
      n_checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== exp_pc || dec_next_pc_o !== npc) begin
        n_fail++; $display("FAIL rnd_capture t=%0d got valid=%0b pc=%0h npc=%0h exp 1/%0h/%0h", t, dec_valid_o, dec_pc_o, dec_next_pc_o, exp_pc, npc);
      end
      n_checks++; if (dec_opcode_o !== op || dec_length_o !== len) begin n_fail++; $display("FAIL rnd_opcode t=%0d got %0h/%0d exp %0h/%0d", t, dec_opcode_o, dec_length_o, op, len); end
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        tick();
        n_checks++; if (dec_valid_o !== 1'b1 || dec_opcode_o !== op) begin n_fail++; $display("FAIL rnd_stable t=%0d got valid=%0b op=%0h exp 1/%0h", t, dec_valid_o, dec_opcode_o, op); end
      end
      dec_ready_in = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        tgt = 20'($urandom);
        jump_in = 1'b1;
        jump_addr_in = tgt;
        tick();
        jump_in = 1'b0;
        dec_ready_in = 1'b0;
        n_checks++; if (ibus_fetch_ack_o !== 1'b0 || ibus_flush_q_o !== 1'b1 || dec_valid_o !== 1'b0) begin
          n_fail++; $display("FAIL rnd_squash t=%0d got ack=%0b flush=%0b valid=%0b exp 0/1/0", t, ibus_fetch_ack_o, ibus_flush_q_o, dec_valid_o);
        end
        exp_pc = tgt;
        tick();
      end else begin
        tick();
        dec_ready_in = 1'b0;
        n_checks++; if (ibus_fetch_ack_o !== 1'b1 || ibus_size_o !== len || ibus_addr_o !== npc || ibus_fetch_o !== 1'b1) begin
          n_fail++; $display("FAIL rnd_ack t=%0d got ack=%0b size=%0d addr=%0h fetch=%0b exp 1/%0d/%0h/1", t, ibus_fetch_ack_o, ibus_size_o, ibus_addr_o, ibus_fetch_o, len, npc);
        end
        exp_pc = npc;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_in = 1'b1;
    ibus_ready_in = 1'b0;
    ibus_addr_in = '0;
    ibus_pre_fetched_opcode_in = '0;
    ibus_pre_fetched_opcode_length_in = '0;
    dec_ready_in = 1'b0;
    jump_in = 1'b0;
    jump_addr_in = '0;
`ifdef SATURN_FETCH_BKPT_EN
    bkpt_en_in = 1'b0;
    bkpt_addr_in = '0;
    resume_in = 1'b0;
`endif
    test_reset();
    test_basic();
    test_wrap();
    test_jump_squash();
    test_len_zero();
`ifdef SATURN_FETCH_BKPT_EN
    test_bkpt();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
